alu_arbiter: RTL and testbench

Shares the single 32-bit ALU among `N_REQ` requesters. Each request carries a 2-bit ALU op and two operands; the block picks one requester with round-robin priority, registers its operands into the ALU, captures the result and NZCV flags one cycle later, and returns them through a valid/ready response port tagged with the requester index. It sits between the ALU and its clients (datapath, address generator, test sequencer), and no client drives the ALU directly.

---
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 32-bit ALU among N_REQ requesters.
// Each grant registers its operands, captures the result and flags, and returns them tagged with the requester id.
//
// state | meaning
// IDLE  | searching for a request from rr_ptr upward; grant fires combinationally
// EXEC  | ALU operands stable; result and flags captured on the edge
// RESP  | response held until rsp_valid && rsp_ready
module alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [2*N_REQ-1:0]   req_op,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [1:0]           alu_ctrl,
  input  logic [31:0]          alu_result,
  input  logic [3:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic [3:0]           rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   rr_ptr_nxt;
  logic [2*N_REQ-1:0] rot;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_fire;
  logic [1:0]        sel_op;
  logic [31:0]       sel_a;
  logic [31:0]       sel_b;

  // Rotating the request vector by rr_ptr turns the wrapping search into a lowest-set-bit search.
  always_comb begin : rr_search
    int sum;
    sum         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    rot         = {req_valid, req_valid} >> rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        grant_found = 1'b1;
        sum = int'(rr_ptr) + k;
        if (sum >= N_REQ) sum = sum - N_REQ;
        grant_idx = ID_W'(sum);
      end
    end
  end

  assign grant_fire = rst_n && (state == IDLE) && grant_found;
  assign rr_ptr_nxt = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_op = req_op[2*k +: 2];
        sel_a  = req_a[32*k +: 32];
        sel_b  = req_b[32*k +: 32];
        req_ready[k] = grant_fire;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_id     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      if (grant_fire) begin
        alu_ctrl <= sel_op;
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        rsp_id   <= grant_idx;
        rr_ptr   <= rr_ptr_nxt;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        rsp_valid  <= 1'b1;
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU closes the loop, expectations go into a
// scoreboard queue and a monitor compares every response handshake against it.
module tb_alu_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [31:0]    alu_a, alu_b;
  logic [1:0]     alu_ctrl;
  logic [31:0]    alu_result;
  logic [3:0]     alu_flags;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [31:0]    rsp_result;
  logic [3:0]     rsp_flags;

  alu_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: ADD/SUB/AND/OR with flags {N,Z,C,V}, carry = not-borrow on SUB.
  logic [31:0] bb, rr;
  logic [32:0] sum;
  always_comb begin
    bb  = (alu_ctrl == 2'b01) ? ~alu_b : alu_b;
    sum = {1'b0, alu_a} + {1'b0, bb} + {32'd0, (alu_ctrl == 2'b01)};
    case (alu_ctrl)
      2'b10:   rr = alu_a & alu_b;
      2'b11:   rr = alu_a | alu_b;
      default: rr = sum[31:0];
    endcase
    alu_result = rr;
    alu_flags  = {rr[31], (rr == 32'd0), (~alu_ctrl[1] & sum[32]),
                  (~alu_ctrl[1] & (alu_a[31] == bb[31]) & (sum[31] != alu_a[31]))};
  end

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] res, input logic [3:0] fl);
    exp_t e;
    e.id = id; e.res = res; e.fl = fl;
    sb.push_back(e);
  endtask

  // Monitor: every handshake must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rsp: got id=%0d result=%h want none", rsp_id, rsp_result);
        end else begin
          e = sb.pop_front();
          chk("rsp_id",     32'(rsp_id),    32'(e.id));
          chk("rsp_result", rsp_result,     e.res);
          chk("rsp_flags",  32'(rsp_flags), 32'(e.fl));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[2*i +: 2] = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // One cycle: sample req_ready mid-cycle, then a granted requester drops its request unless held.
  task automatic cycle_step(input bit hold, output logic [N-1:0] g);
    @(negedge clk);
    g = req_ready;
    total++;
    if (!$onehot0(g)) begin
      bad++;
      $display("FAIL ready_onehot: got %b want one-hot or zero", g);
    end
    @(posedge clk); #1;
    if (!hold) req_valid = req_valid & ~g;
  endtask

  task automatic run_grants(input int n, input bit hold);
    logic [N-1:0] g;
    int seen = 0;
    for (int c = 0; c < 200 && seen < n; c++) begin
      cycle_step(hold, g);
      if (g != '0) seen++;
    end
    chk("grant_count", 32'(seen), 32'(n));
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 100) begin
      @(posedge clk);
      c++;
    end
    #1;
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_a"},      alu_a,           32'd0);
    chk({tag, "_alu_b"},      alu_b,           32'd0);
    chk({tag, "_alu_ctrl"},   32'(alu_ctrl),   32'd0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, "_rsp_id"},     32'(rsp_id),     32'd0);
    chk({tag, "_rsp_result"}, rsp_result,      32'd0);
    chk({tag, "_rsp_flags"},  32'(rsp_flags),  32'd0);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] g;
    rst_n = 1'b0; req_valid = '1; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 2'b00, 32'd1, 32'd1);

    // Reset: outputs at reset values and no grant even with every request pending.
    @(posedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;

    // Idle: nothing requested, nothing granted.
    for (int i = 0; i < 3; i++) begin
      cycle_step(1'b0, g);
      chk("idle0_ready", 32'(g), 32'd0);
    end

    // Single request with exact timing: grant at T, EXEC at T+1, response at T+2.
    set_req(0, 2'b00, 32'h7FFF_FFFF, 32'd1);
    push(2'd0, 32'h8000_0000, 4'b1001);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("single_grant_T", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("single_alu_a", alu_a, 32'h7FFF_FFFF);
    chk("single_alu_b", alu_b, 32'd1);
    chk("single_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("single_T1_valid", 32'(rsp_valid), 32'd0);
    chk("single_T1_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_T2_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    drain();

    // Contention after a fresh reset: grant order 0,1,2,3,0.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 2'b00, 32'd1,  32'd2);
    set_req(1, 2'b01, 32'd10, 32'd3);
    set_req(2, 2'b01, 32'd5,  32'd5);
    set_req(3, 2'b10, 32'hFF, 32'h0F);
    push(2'd0, 32'd3,  4'b0000);
    push(2'd1, 32'd7,  4'b0010);
    push(2'd2, 32'd0,  4'b0110);
    push(2'd3, 32'hF,  4'b0000);
    push(2'd0, 32'd3,  4'b0000);
    req_valid = 4'b1111;
    run_grants(5, 1'b1);
    req_valid = '0;
    drain();

    // Wrap and skip: after a grant to 2, only 0 and 1 pending -> 0 then 1.
    set_req(2, 2'b00, 32'd2, 32'd2);
    push(2'd2, 32'd4, 4'b0000);
    req_valid = 4'b0100;
    run_grants(1, 1'b0);
    drain();
    set_req(0, 2'b11, 32'h0000_FFFF, 32'hFFFF_0000);
    set_req(1, 2'b00, 32'hFFFF_FFFF, 32'd1);
    push(2'd0, 32'hFFFF_FFFF, 4'b1000);
    push(2'd1, 32'd0,         4'b0110);
    req_valid = 4'b0011;
    run_grants(2, 1'b0);
    drain();

    // Back-pressure: response held for 10 cycles with another request waiting.
    rsp_ready = 1'b0;
    set_req(3, 2'b10, 32'hF0F0_F0F0, 32'hFF00_FF00);
    push(2'd3, 32'hF000_F000, 4'b1000);
    push(2'd0, 32'd0,         4'b0100);
    req_valid = 4'b1000;
    run_grants(1, 1'b0);
    set_req(0, 2'b00, 32'd0, 32'd0);
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid",  32'(rsp_valid), 32'd1);
      chk("bp_result", rsp_result,     32'hF000_F000);
      chk("bp_id",     32'(rsp_id),    32'd3);
      chk("bp_ready",  32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    drain();

    // Reset mid-op: asserted in EXEC, the in-flight op must vanish.
    set_req(1, 2'b01, 32'd9, 32'd4);
    req_valid = 4'b0010;
    run_grants(1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midop");
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      cycle_step(1'b0, g);
      chk("post_reset_idle_valid", 32'(rsp_valid), 32'd0);
    end
    set_req(0, 2'b01, 32'd3, 32'd5);
    set_req(2, 2'b10, 32'h1234_5678, 32'd0);
    push(2'd0, 32'hFFFF_FFFE, 4'b1000);
    push(2'd2, 32'd0,         4'b0100);
    req_valid = 4'b0101;
    run_grants(2, 1'b0);
    drain();

    // OR of zeros, then a quiet idle stretch.
    set_req(1, 2'b11, 32'd0, 32'd0);
    push(2'd1, 32'd0, 4'b0100);
    req_valid = 4'b0010;
    run_grants(1, 1'b0);
    drain();
    for (int i = 0; i < 8; i++) begin
      cycle_step(1'b0, g);
      chk("idle_ready", 32'(g), 32'd0);
      chk("idle_valid", 32'(rsp_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
